// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the register-file write-back path.
package wb_arbiter_pkg;

  localparam int WB_REG_W = 5;
  localparam int WB_DW    = 32;

  typedef logic [WB_REG_W-1:0] wb_reg_t;

  localparam wb_reg_t REG_ZERO = '0;

  typedef struct packed {
    wb_reg_t           wreg;
    logic [WB_DW-1:0]  data;
  } wb_entry_t;

  // Register 0 is hard-wired and indices past the implemented range have no storage.
  function automatic logic reg_writable(wb_reg_t r, int num_regs);
    return (r != REG_ZERO) && (int'(r) < num_regs);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for write-back entries; exposes per-slot validity and register tags.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_entry_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  T                             i_din,
  input  logic                         i_pop,
  output T                             o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [DEPTH-1:0]             o_entry_valid,
  output wb_reg_t [DEPTH-1:0]          o_entry_reg
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  T              r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign w_push = i_push & !o_full;
  assign w_pop  = i_pop & !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is not reset; slot validity comes from the pointers and count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  // A slot is live when its distance from the read pointer is below the fill count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_entry_valid[i] = {1'b0, AW'(i) - r_rd_ptr} < r_count;
      o_entry_reg[i]   = r_mem[i].wreg;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Two-source round-robin write-back arbiter feeding the register file through a small FIFO.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = 9,
  parameter int DW       = WB_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic [WB_REG_W-1:0]  s0_reg,
  input  logic [DW-1:0]        s0_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [WB_REG_W-1:0]  s1_reg,
  input  logic [DW-1:0]        s1_data,
  input  logic                 wb_stall,
  output logic                 write_back_en,
  output logic [WB_REG_W-1:0]  write_back_reg,
  output logic [DW-1:0]        write_back,
  output logic [NUM_REGS-1:0]  pending_mask
);

  typedef struct packed {
    wb_reg_t        wreg;
    logic [DW-1:0]  data;
  } entry_t;

  logic                 r_last_grant;
  logic                 w_grant;
  logic                 w_xfer;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  entry_t               w_in;
  entry_t               w_head;
  logic [DEPTH-1:0]     w_entry_valid;
  wb_reg_t [DEPTH-1:0]  w_entry_reg;

  always_comb begin
    if (s0_valid && s1_valid) w_grant = ~r_last_grant;
    else if (s1_valid)        w_grant = 1'b1;
    else                      w_grant = 1'b0;
  end

  // No pass-through when full: a same-cycle pop does not open a slot for the sources.
  assign s0_ready = !rst & !w_grant & !w_full;
  assign s1_ready = !rst &  w_grant & !w_full;
  assign w_xfer   = (s0_valid & s0_ready) | (s1_valid & s1_ready);

  always_comb begin
    if (w_grant) w_in = '{wreg: s1_reg, data: s1_data};
    else         w_in = '{wreg: s0_reg, data: s0_data};
  end

  assign w_push = w_xfer & reg_writable(w_in.wreg, NUM_REGS);

  // Dropped writes still complete a handshake, so they still rotate priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_last_grant <= 1'b1;
    else if (w_xfer) r_last_grant <= w_grant;
  end

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_din         (w_in),
    .i_pop         (write_back_en),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_entry_valid (w_entry_valid),
    .o_entry_reg   (w_entry_reg)
  );

  assign write_back_en  = !w_empty & !wb_stall;
  assign write_back_reg = w_empty ? '0 : w_head.wreg;
  assign write_back     = w_empty ? '0 : w_head.data;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_entry_valid[i] && (w_entry_reg[i] == WB_REG_W'(r))) pending_mask[r] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: latency, round-robin, full/stall, drops, ordering, reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0;
  logic        s0_ready;
  logic [4:0]  s0_reg = '0;
  logic [31:0] s0_data = '0;
  logic        s1_valid = 1'b0;
  logic        s1_ready;
  logic [4:0]  s1_reg = '0;
  logic [31:0] s1_data = '0;
  logic        wb_stall = 1'b0;
  logic        write_back_en;
  logic [4:0]  write_back_reg;
  logic [31:0] write_back;
  logic [8:0]  pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.DEPTH(4), .NUM_REGS(9), .DW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .s0_valid       (s0_valid),
    .s0_ready       (s0_ready),
    .s0_reg         (s0_reg),
    .s0_data        (s0_data),
    .s1_valid       (s1_valid),
    .s1_ready       (s1_ready),
    .s1_reg         (s1_reg),
    .s1_data        (s1_data),
    .wb_stall       (wb_stall),
    .write_back_en  (write_back_en),
    .write_back_reg (write_back_reg),
    .write_back     (write_back),
    .pending_mask   (pending_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1-3 time units after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    settle();
    check("rst_en",    64'(write_back_en), 64'd0);
    check("rst_mask",  64'(pending_mask), 64'd0);
    check("rst_rdy0",  64'(s0_ready), 64'd0);
    check("rst_reg",   64'(write_back_reg), 64'd0);
    step();
    rst = 1'b0;

    // 1: single ALU write, one-cycle latency
    s0_valid = 1'b1; s0_reg = 5'd3; s0_data = 32'hDEAD_BEEF;
    settle();
    check("t1_rdy0", 64'(s0_ready), 64'd1);
    check("t1_en_pre", 64'(write_back_en), 64'd0);
    step();
    s0_valid = 1'b0;
    settle();
    check("t1_en",   64'(write_back_en), 64'd1);
    check("t1_reg",  64'(write_back_reg), 64'd3);
    check("t1_data", 64'(write_back), 64'hDEAD_BEEF);
    check("t1_mask", 64'(pending_mask), 64'h008);
    step();
    settle();
    check("t1_en_post",   64'(write_back_en), 64'd0);
    check("t1_mask_post", 64'(pending_mask), 64'd0);
    check("t1_data_post", 64'(write_back), 64'd0);

    // 2: both sources valid, grants alternate 0,1,0,1 from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s0_valid = 1'b1; s0_reg = 5'(2 * ((i + 1) / 2) + 1); s0_data = 32'(s0_reg) * 32'h11;
      s1_valid = 1'b1; s1_reg = 5'(2 * (i / 2) + 2);       s1_data = 32'(s1_reg) * 32'h11;
      settle();
      check($sformatf("t2_rdy0_%0d", i), 64'(s0_ready), 64'(i % 2 == 0));
      check($sformatf("t2_rdy1_%0d", i), 64'(s1_ready), 64'(i % 2 == 1));
      check($sformatf("t2_en_%0d", i), 64'(write_back_en), 64'(i > 0));
      if (i > 0) begin
        check($sformatf("t2_reg_%0d", i), 64'(write_back_reg), 64'(i));
        check($sformatf("t2_data_%0d", i), 64'(write_back), 64'(i * 32'h11));
      end
      step();
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    settle();
    check("t2_reg_last",  64'(write_back_reg), 64'd4);
    check("t2_data_last", 64'(write_back), 64'h44);
    step();
    settle();
    check("t2_en_idle", 64'(write_back_en), 64'd0);

    // 3: stalled port fills the FIFO; fifth write waits, no pass-through when full
    wb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s0_valid = 1'b1; s0_reg = 5'(i); s0_data = 32'(i) << 8;
      step();
    end
    s0_reg = 5'd6; s0_data = 32'h600;
    settle();
    check("t3_full_rdy0", 64'(s0_ready), 64'd0);
    check("t3_full_rdy1", 64'(s1_ready), 64'd0);
    check("t3_stall_en",  64'(write_back_en), 64'd0);
    check("t3_mask",      64'(pending_mask), 64'h01E);
    step();
    wb_stall = 1'b0;
    settle();
    check("t3_r0_en",   64'(write_back_en), 64'd1);
    check("t3_r0_reg",  64'(write_back_reg), 64'd1);
    check("t3_r0_rdy0", 64'(s0_ready), 64'd0);
    step();
    settle();
    check("t3_r1_reg",  64'(write_back_reg), 64'd2);
    check("t3_r1_rdy0", 64'(s0_ready), 64'd1);
    step();
    s0_valid = 1'b0;
    settle();
    check("t3_r2_reg", 64'(write_back_reg), 64'd3);
    step();
    settle();
    check("t3_r3_reg", 64'(write_back_reg), 64'd4);
    check("t3_r3_data", 64'(write_back), 64'h400);
    step();
    settle();
    check("t3_r4_reg",  64'(write_back_reg), 64'd6);
    check("t3_r4_data", 64'(write_back), 64'h600);
    check("t3_r4_mask", 64'(pending_mask), 64'h040);
    step();
    settle();
    check("t3_drained", 64'(write_back_en), 64'd0);

    // 4: writes to reg 0 and reg 12 handshake but are dropped
    s1_valid = 1'b1; s1_reg = 5'd0; s1_data = 32'hBAD0;
    settle();
    check("t4_rdy_r0", 64'(s1_ready), 64'd1);
    step();
    s1_reg = 5'd12; s1_data = 32'hBAD1;
    settle();
    check("t4_rdy_r12", 64'(s1_ready), 64'd1);
    check("t4_en_a",    64'(write_back_en), 64'd0);
    step();
    s1_valid = 1'b0;
    settle();
    check("t4_en_b",   64'(write_back_en), 64'd0);
    check("t4_mask_b", 64'(pending_mask), 64'd0);

    // 5: two writes to reg 5 retire in order; mask holds until the second pops
    s0_valid = 1'b1; s0_reg = 5'd5; s0_data = 32'h1;
    step();
    s0_data = 32'h2;
    settle();
    check("t5_a_data", 64'(write_back), 64'h1);
    check("t5_a_mask", 64'(pending_mask), 64'h020);
    step();
    s0_valid = 1'b0;
    settle();
    check("t5_b_reg",  64'(write_back_reg), 64'd5);
    check("t5_b_data", 64'(write_back), 64'h2);
    check("t5_b_mask", 64'(pending_mask), 64'h020);
    step();
    settle();
    check("t5_c_mask", 64'(pending_mask), 64'd0);

    // 6: asynchronous reset with three queued writes, then first tie goes to src0
    wb_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s0_valid = 1'b1; s0_reg = 5'(i); s0_data = 32'(i);
      step();
    end
    s0_valid = 1'b0;
    settle();
    check("t6_mask_q", 64'(pending_mask), 64'h00E);
    wb_stall = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_en",   64'(write_back_en), 64'd0);
    check("t6_rst_mask", 64'(pending_mask), 64'd0);
    step();
    rst = 1'b0;
    s0_valid = 1'b1; s0_reg = 5'd7; s0_data = 32'h77;
    s1_valid = 1'b1; s1_reg = 5'd8; s1_data = 32'h88;
    settle();
    check("t6_tie_rdy0", 64'(s0_ready), 64'd1);
    check("t6_tie_rdy1", 64'(s1_ready), 64'd0);
    check("t6_tie_en",   64'(write_back_en), 64'd0);
    step();
    s0_valid = 1'b0;
    settle();
    check("t6_wr_reg",  64'(write_back_reg), 64'd7);
    check("t6_wr_data", 64'(write_back), 64'h77);
    check("t6_rdy1",    64'(s1_ready), 64'd1);
    step();
    s1_valid = 1'b0;
    settle();
    check("t6_wr2_reg", 64'(write_back_reg), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
